key_en_debounce: RTL and testbench
==================================

# key_en_debounce

Debounces and synchronizes a raw, asynchronous key/switch input and produces a clean enable level plus single-cycle edge strobes. It sits directly upstream of the `example1` stage: its `en` output drives that stage's `en` input, replacing the hand-driven enable used in simulation. The `en_rise` and `en_fall` strobes are available for downstream logic that needs event pulses rather than a level.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20. Number of consecutive cycles the new key level must be stable before `en` changes. Legal values are ≥ 2. Hardware builds override it, e.g. 1_000_000 for 20 ms at 50 MHz.
- `CNT_W`, default 20. Width of the debounce counter. Must satisfy 2^`CNT_W` ≥ `DEBOUNCE_CYCLES`.
- `KEY_ACTIVE_LOW`, default 1. When 1, `key_in` = 0 means pressed. When 0, `key_in` = 1 means pressed.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1. System clock; all state changes on the rising edge.
- `areset` input 1. Asynchronous, active-high reset.
- `key_in` input 1. Raw key level. It is asynchronous to `clk` and may bounce.
- `en` output 1. Debounced level: 1 while the key is considered pressed. Registered.
- `en_rise` output 1. One-cycle strobe, high during the first cycle `en` = 1. Registered.
- `en_fall` output 1. One-cycle strobe, high during the first cycle `en` = 0 after a release. Registered.
- `busy` output 1. High while a transition is being qualified (state PRESS_CHK or REL_CHK). Registered.

## Operation

- **Synchronizer:** two flip-flops, `key_s1` then `key_s2`.
  - Both reset to the inactive key level (1 if `KEY_ACTIVE_LOW` = 1, else 0), so a press is never detected immediately after reset.
- **Active level:** `key_act` = `KEY_ACTIVE_LOW` ? ~`key_s2` : `key_s2`.
- **State machine:** states IDLE, PRESS_CHK, HELD, REL_CHK; 2-bit state register; debounce counter `cnt`.
  - **IDLE** (`en` = 0):
    - `key_act` = 1 → PRESS_CHK, `cnt` ← 0.
  - **PRESS_CHK** (`en` = 0, `busy` = 1):
    - `key_act` = 0 → IDLE, `cnt` ← 0. This is a glitch; no strobe is issued.
    - `key_act` = 1 and `cnt` = `DEBOUNCE_CYCLES`−1 → HELD, `en` ← 1, `en_rise` ← 1.
    - Otherwise `cnt` ← `cnt`+1.
  - **HELD** (`en` = 1):
    - `key_act` = 0 → REL_CHK, `cnt` ← 0.
  - **REL_CHK** (`en` = 1, `busy` = 1): mirror of PRESS_CHK.
    - `key_act` = 1 → HELD, no strobe.
    - `key_act` = 0 and `cnt` = `DEBOUNCE_CYCLES`−1 → IDLE, `en` ← 0, `en_fall` ← 1.
- **Strobes:** `en_rise` and `en_fall` are forced to 0 on every cycle other than the transition cycle. They are never both high.
- **Terminal-count edge:** the transition is taken only if `key_act` is still at the new level on that same edge. A bounce at the terminal edge restarts qualification, as defined above.
- **Counter:** `cnt` never exceeds `DEBOUNCE_CYCLES`−1 and never wraps. Width arithmetic is unsigned `CNT_W` bits.
- **Reset (including mid-operation, any state):**
  - Immediately and asynchronously: state = IDLE, `cnt` = 0, `en` = 0, `en_rise` = 0, `en_fall` = 0, `busy` = 0, synchronizer flops = inactive level.
  - Reset asserted in HELD does not produce an `en_fall` pulse.
- **Illegal state encodings:** must recover to IDLE on the next edge.

## Timing

- **Reset values:** `en` = 0, `en_rise` = 0, `en_fall` = 0, `busy` = 0.
- **Press latency:**
  - Let edge k be the first rising edge that samples the new stable level into `key_s1`.
  - `key_s2` updates at k+1; PRESS_CHK is entered at k+2 with `cnt` = 0.
  - `en` and `en_rise` go high at edge k+`DEBOUNCE_CYCLES`+2. With the default of 20, that is edge k+22.
  - `en_rise` is low again at edge k+23.
- **Release latency:** identical, giving `en` = 0 and `en_fall` = 1 at edge k+`DEBOUNCE_CYCLES`+2.
- **Glitch rejection:** a key-level excursion shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no change on `en` and no strobe. `busy` does go high for the duration of the excursion.
- **Busy window:** `busy` is high from edge k+2 until the transition edge, inclusive of neither end's following cycle.
- **Reset release:** after `areset` deasserts, the first possible `en_rise` is `DEBOUNCE_CYCLES`+2 edges after the key is seen active.

## Test plan

All scenarios use `PERIOD` = 10 ns, `DEBOUNCE_CYCLES` = 20, `KEY_ACTIVE_LOW` = 1.

- **Reset values:** hold `areset` = 1 for 2 cycles with `key_in` = 0 (pressed) → all outputs 0 throughout reset. After release, `en` rises exactly 22 edges after the first sampling edge.
- **Clean press/release:**
  - Drive `key_in` to 0, hold 40 cycles, then 1 → `en` = 1 at edge k+22, `en_rise` high for exactly 1 cycle.
  - `en` = 0 22 edges after the release is sampled, with one `en_fall` pulse.
- **Glitch:** drive `key_in` low for 15 cycles, then high → `en` stays 0, no strobes, `busy` high for about 15 cycles then 0.
- **Bounce:**
  - Toggle `key_in` 5 times with 3-cycle low/high segments, then hold low for 30 cycles → exactly one `en_rise`, 22 edges after the last transition is sampled.
  - Mirror the pattern on release → exactly one `en_fall`.
- **Terminal-edge bounce:** flip `key_in` back so that `key_act` = 0 at the edge where `cnt` = 19 → no transition, state returns to IDLE, `cnt` = 0.
- **Reset mid-operation:** assert `areset` asynchronously (mid-cycle) while in HELD → `en` = 0 immediately with no `en_fall`. After release with the key still pressed, `en` re-asserts 22 edges later.

Source files
------------

// File: rtl/key_en_debounce.sv
// Key/switch debouncer: two-flop synchronizer, then a four-state
// qualification FSM that produces a clean enable level, one-cycle
// rise/fall strobes and a busy flag while a new level is being qualified.
module key_en_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic areset,
    input  logic key_in,
    output logic en,
    output logic en_rise,
    output logic en_fall,
    output logic busy
);

    // Synchronizer flops come out of reset at the released level so that
    // a key held down through reset still has to be qualified afterwards.
    localparam logic             KEY_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic             key_s1;
    logic             key_s2;
    logic             key_act;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchronizer for the asynchronous raw key.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            key_s1 <= KEY_IDLE;
            key_s2 <= KEY_IDLE;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    assign key_act = KEY_ACTIVE_LOW ? ~key_s2 : key_s2;

    // Qualification FSM; all outputs are registered here. The terminal
    // count only commits if key_act still shows the new level on that edge.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            cnt     <= '0;
            en      <= 1'b0;
            en_rise <= 1'b0;
            en_fall <= 1'b0;
            busy    <= 1'b0;
        end else begin
            en_rise <= 1'b0;
            en_fall <= 1'b0;
            case (state)
                IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    if (key_act) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                PRESS_CHK: begin
                    if (!key_act) begin
                        // bounce or glitch: abandon silently
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        en      <= 1'b1;
                        en_rise <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    en   <= 1'b1;
                    busy <= 1'b0;
                    if (!key_act) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                REL_CHK: begin
                    if (key_act) begin
                        state <= HELD;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        en      <= 1'b0;
                        en_fall <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_en_debounce.sv
// Directed bench for key_en_debounce (DEBOUNCE_CYCLES=20, active-low key).
// Latency is counted in posedges from edge k, the first edge that samples
// the new key level (k itself is 0), so a qualified change shows at 22.
module tb_key_en_debounce;

    localparam int PERIOD = 10;
    localparam int DC     = 20;
    localparam int LAT    = DC + 2;

    logic clk = 1'b0;
    logic areset;
    logic key_in;
    logic en, en_rise, en_fall, busy;

    int vecs = 0;
    int errs = 0;

    int rise_cnt = 0;
    int fall_cnt = 0;
    int busy_cnt = 0;
    int en_cnt   = 0;
    int both_cnt = 0;
    int lat;

    key_en_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(20),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .areset(areset),
        .key_in(key_in),
        .en(en),
        .en_rise(en_rise),
        .en_fall(en_fall),
        .busy(busy)
    );

    always #(PERIOD/2) clk = ~clk;

    // Observe strobes and flags on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!areset) begin
            rise_cnt += int'(en_rise);
            fall_cnt += int'(en_fall);
            busy_cnt += int'(busy);
            en_cnt   += int'(en);
            both_cnt += int'(en_rise & en_fall);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        rise_cnt = 0;
        fall_cnt = 0;
        busy_cnt = 0;
        en_cnt   = 0;
        both_cnt = 0;
    endtask

    // Drive key at a falling edge and hold for n cycles.
    task automatic seg(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Called just after key_in changes at a falling edge (or after reset
    // release); returns the edge index, relative to k, at which en reaches
    // target, or -1 if it never does within the budget.
    task automatic measure(input logic target, input int budget, output int l);
        l = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (en === target) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        // ---- reset values, key already pressed ----
        areset = 1'b1;
        key_in = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_en", int'(en), 0);
            chk("rst_rise", int'(en_rise), 0);
            chk("rst_fall", int'(en_fall), 0);
            chk("rst_busy", int'(busy), 0);
        end
        areset = 1'b0;
        clr();
        measure(1'b1, 40, lat);
        chk("rst_release_lat", lat, LAT);
        chk("rst_release_rise", int'(en_rise), 1);
        @(negedge clk);
        chk("rise_one_cycle", int'(en_rise), 0);
        chk("en_held", int'(en), 1);
        chk("busy_held", int'(busy), 0);

        // ---- clean release then clean press/release ----
        key_in = 1'b1;
        measure(1'b0, 40, lat);
        chk("release_lat", lat, LAT);
        chk("release_fall", int'(en_fall), 1);
        @(negedge clk);
        chk("fall_one_cycle", int'(en_fall), 0);

        clr();
        key_in = 1'b0;
        measure(1'b1, 40, lat);
        chk("press_lat", lat, LAT);
        repeat (40 - LAT - 1) @(negedge clk);
        key_in = 1'b1;
        measure(1'b0, 40, lat);
        chk("press_release_lat", lat, LAT);
        repeat (5) @(negedge clk);
        chk("press_rise_cnt", rise_cnt, 1);
        chk("press_fall_cnt", fall_cnt, 1);

        // ---- glitch of 15 cycles: busy for 15, nothing else ----
        clr();
        seg(1'b0, 15);
        seg(1'b1, 30);
        chk("glitch_en", en_cnt, 0);
        chk("glitch_rise", rise_cnt, 0);
        chk("glitch_fall", fall_cnt, 0);
        chk("glitch_busy", busy_cnt, 15);

        // ---- bounce on press ----
        clr();
        seg(1'b0, 3);
        seg(1'b1, 3);
        seg(1'b0, 3);
        seg(1'b1, 3);
        key_in = 1'b0;
        measure(1'b1, 40, lat);
        chk("bounce_press_lat", lat, LAT);
        repeat (30 - LAT - 1) @(negedge clk);
        chk("bounce_rise_cnt", rise_cnt, 1);

        // ---- bounce on release ----
        clr();
        seg(1'b1, 3);
        seg(1'b0, 3);
        seg(1'b1, 3);
        seg(1'b0, 3);
        key_in = 1'b1;
        measure(1'b0, 40, lat);
        chk("bounce_release_lat", lat, LAT);
        repeat (10) @(negedge clk);
        chk("bounce_fall_cnt", fall_cnt, 1);
        chk("bounce_rise_none", rise_cnt, 0);

        // ---- terminal-edge bounce: 20 low cycles just misses ----
        clr();
        seg(1'b0, DC);
        seg(1'b1, 10);
        chk("term_en", en_cnt, 0);
        chk("term_rise", rise_cnt, 0);
        chk("term_busy", busy_cnt, DC);
        chk("term_idle_busy", int'(busy), 0);
        // one more low cycle is just enough, from a zeroed counter
        seg(1'b0, DC + 1);
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("term_plus1_rise", rise_cnt, 1);
        measure(1'b0, 40, lat);
        repeat (5) @(negedge clk);
        chk("term_plus1_fall", fall_cnt, 1);

        // ---- reset mid-operation while held ----
        key_in = 1'b0;
        measure(1'b1, 40, lat);
        chk("held_before_rst", lat, LAT);
        repeat (3) @(negedge clk);
        clr();
        @(posedge clk);
        #3;
        areset = 1'b1;
        #1;
        chk("midrst_en", int'(en), 0);
        chk("midrst_fall", int'(en_fall), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        measure(1'b1, 40, lat);
        chk("midrst_relat", lat, LAT);
        chk("midrst_no_fall", fall_cnt, 0);
        chk("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
